// File: rtl/corescore_uart_pkg.sv
// Shared constants, FSM state encoding and baud divisor helper for the
// corescore UART transmitter.
package corescore_uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   localparam logic [7:0] LF = 8'h0A;

   // ST_EOL is never entered: an LF frame runs through START..STOP with the
   // EOL flag set.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PAR,
      ST_STOP,
      ST_EOL
   } state_t;

   function automatic int baud_div(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/corescore_sync_fifo.sv
// Single-clock FIFO with combinational read of the head entry; a pushed
// entry becomes visible one cycle after the write.
module corescore_sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  logic [WIDTH-1:0]        wdata,
   input  logic                    pop,
   output logic [WIDTH-1:0]        rdata,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_MAX);
   assign empty   = (count == '0);
   assign level   = count;
   assign rdata   = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/corescore_uart_tx.sv
// AXI-stream to UART transmitter: FIFO-buffered bytes serialised with
// configurable framing, optional LF after each tlast.
module corescore_uart_tx
   import corescore_uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ  = 16000000,
   parameter int BAUD_RATE    = 57600,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int PARITY       = 0,
   parameter int FIFO_DEPTH   = 16,
   parameter int EOL_ON_TLAST = 1
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [DATA_BITS-1:0]         i_tdata,
   input  logic                         i_tlast,
   input  logic                         i_tvalid,
   output logic                         o_tready,
   output logic                         o_uart_tx,
   output logic                         o_busy,
   output logic [$clog2(FIFO_DEPTH):0]  o_level
);

   localparam int DIV = baud_div(CLK_FREQ_HZ, BAUD_RATE);
   localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
   localparam logic [CW-1:0]        CNT_RELOAD = CW'(DIV - 1);
   localparam logic [CW-1:0]        CNT_ONE    = CW'(1);
   localparam logic [2:0]           LAST_BIT   = 3'(DATA_BITS - 1);
   localparam logic [DATA_BITS-1:0] LF_WORD    = LF[DATA_BITS-1:0];
   localparam logic                 ODD_INV    = (PARITY == PARITY_ODD);
   localparam logic                 LF_PAR     = (^LF_WORD) ^ ODD_INV;

   if (DIV < 2) begin : g_div_check
      $fatal(1, "corescore_uart_tx: baud divisor must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bits_check
      $fatal(1, "corescore_uart_tx: DATA_BITS must be 5..8");
   end

   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [DATA_BITS:0]   fifo_rdata;
   logic [DATA_BITS-1:0] pop_data;
   logic                 pop_last;
   logic                 pop_par;

   state_t               state_reg, state_next;
   logic [CW-1:0]        cnt_reg, cnt_next;
   logic [2:0]           bit_reg, bit_next;
   logic                 stop_reg, stop_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic                 par_reg, par_next;
   logic                 last_reg, last_next;
   logic                 eol_reg, eol_next;
   logic                 tx_reg, tx_next;

   assign o_tready = i_rst_n && !fifo_full;
   assign o_busy   = (state_reg != ST_IDLE) || !fifo_empty;
   assign o_uart_tx = tx_reg;

   corescore_sync_fifo #(
      .WIDTH (DATA_BITS + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .push  (i_tvalid && o_tready),
      .wdata ({i_tlast, i_tdata}),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (o_level)
   );

   assign pop_data = fifo_rdata[DATA_BITS-1:0];
   assign pop_last = fifo_rdata[DATA_BITS];
   assign pop_par  = (^pop_data) ^ ODD_INV;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      bit_next   = bit_reg;
      stop_next  = stop_reg;
      shift_next = shift_reg;
      par_next   = par_reg;
      last_next  = last_reg;
      eol_next   = eol_reg;
      tx_next    = tx_reg;
      fifo_pop   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               shift_next = pop_data;
               par_next   = pop_par;
               last_next  = pop_last;
               eol_next   = 1'b0;
               tx_next    = 1'b0;
               cnt_next   = CNT_RELOAD;
               state_next = ST_START;
            end
         end
         ST_START: begin
            if (cnt_reg != '0) cnt_next = cnt_reg - CNT_ONE;
            else begin
               cnt_next   = CNT_RELOAD;
               bit_next   = '0;
               tx_next    = shift_reg[0];
               shift_next = shift_reg >> 1;
               state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt_reg != '0) cnt_next = cnt_reg - CNT_ONE;
            else begin
               cnt_next = CNT_RELOAD;
               if (bit_reg == LAST_BIT) begin
                  stop_next = 1'b0;
                  if (PARITY != PARITY_NONE) begin
                     tx_next    = par_reg;
                     state_next = ST_PAR;
                  end else begin
                     tx_next    = 1'b1;
                     state_next = ST_STOP;
                  end
               end else begin
                  bit_next   = bit_reg + 3'd1;
                  tx_next    = shift_reg[0];
                  shift_next = shift_reg >> 1;
               end
            end
         end
         ST_PAR: begin
            if (cnt_reg != '0) cnt_next = cnt_reg - CNT_ONE;
            else begin
               cnt_next   = CNT_RELOAD;
               tx_next    = 1'b1;
               state_next = ST_STOP;
            end
         end
         ST_STOP: begin
            if (cnt_reg != '0) cnt_next = cnt_reg - CNT_ONE;
            else if (STOP_BITS == 2 && !stop_reg) begin
               stop_next = 1'b1;
               cnt_next  = CNT_RELOAD;
            end else if (EOL_ON_TLAST != 0 && last_reg && !eol_reg) begin
               // LF frame follows immediately; the set flag prevents a second LF.
               shift_next = LF_WORD;
               par_next   = LF_PAR;
               eol_next   = 1'b1;
               tx_next    = 1'b0;
               cnt_next   = CNT_RELOAD;
               state_next = ST_START;
            end else if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               shift_next = pop_data;
               par_next   = pop_par;
               last_next  = pop_last;
               eol_next   = 1'b0;
               tx_next    = 1'b0;
               cnt_next   = CNT_RELOAD;
               state_next = ST_START;
            end else begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         bit_reg   <= '0;
         stop_reg  <= 1'b0;
         shift_reg <= '0;
         par_reg   <= 1'b0;
         last_reg  <= 1'b0;
         eol_reg   <= 1'b0;
         tx_reg    <= 1'b1;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         bit_reg   <= bit_next;
         stop_reg  <= stop_next;
         shift_reg <= shift_next;
         par_reg   <= par_next;
         last_reg  <= last_next;
         eol_reg   <= eol_next;
         tx_reg    <= tx_next;
      end
   end

endmodule
